// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-port word memory between fetch and load/store, data first with a fetch starvation guard.
// Optional ARB_MISALIGN_CHK_EN adds if_err/d_err and suppresses misaligned memory accesses.
module unified_mem_arbiter #(
    parameter int ADDR_W       = 6,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W+1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [ADDR_W+1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
`ifdef ARB_MISALIGN_CHK_EN
    output logic              if_err,
    output logic              d_err,
`endif
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, RESP_IF, RESP_D_RD, RESP_D_WR} state_e;
    localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

    state_e     state_q, state_d;
    logic [3:0] starve_q, starve_d;
    logic       d_win, if_bad, d_bad, rsp_err;

`ifdef ARB_MISALIGN_CHK_EN
    logic err_q, err_d;
    assign if_bad = |if_addr[1:0];
    assign d_bad  = d_we && !(d_be inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111});
    assign err_d  = if_gnt ? if_bad : (d_gnt & d_bad);
    assign rsp_err = err_q;
    assign if_err = (state_q == RESP_IF) && err_q;
    assign d_err  = (state_q == RESP_D_RD || state_q == RESP_D_WR) && err_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
`else
    assign if_bad  = 1'b0;
    assign d_bad   = 1'b0;
    assign rsp_err = 1'b0;
`endif
    // Byte-offset bits select nothing in a word-wide memory.
    logic unused_ok;
    assign unused_ok = &{1'b0, if_addr[1:0], d_addr[1:0]};

    assign d_win  = d_req && !(if_req && starve_q == LIM);
    assign d_gnt  = rst_n && d_win;
    assign if_gnt = rst_n && if_req && !d_win;

    assign mem_en    = (if_gnt && !if_bad) || (d_gnt && !d_bad);
    assign mem_we    = d_gnt && d_we && !d_bad;
    assign mem_be    = mem_we ? d_be : 4'b0000;
    assign mem_wdata = mem_we ? d_wdata : '0;
    assign mem_addr  = !mem_en ? '0 : d_gnt ? d_addr[ADDR_W+1:2] : if_addr[ADDR_W+1:2];

    assign starve_d = (!if_req || if_gnt) ? 4'd0 : (d_gnt && starve_q != LIM) ? starve_q + 4'd1 : starve_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q  <= IDLE;
            starve_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end

    always_comb
        state_d = if_gnt ? RESP_IF : !d_gnt ? IDLE : d_we ? RESP_D_WR : RESP_D_RD;

    always_comb begin
        if_rvalid = state_q == RESP_IF;
        d_rvalid  = state_q == RESP_D_RD || state_q == RESP_D_WR;
        if_rdata  = (if_rvalid && !rsp_err) ? mem_rdata : '0;
        d_rdata   = (state_q == RESP_D_RD && !rsp_err) ? mem_rdata : '0;
    end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: directed checks of arbitration, starvation guard, responses and reset against a behavioural memory.
module tb_unified_mem_arbiter;
    logic        clk = 1'b0, rst_n;
    logic        if_req, if_gnt, if_rvalid;
    logic [7:0]  if_addr, d_addr;
    logic [31:0] if_rdata, d_wdata, d_rdata, mem_wdata, mem_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [3:0]  d_be, mem_be;
    logic        mem_en, mem_we;
    logic [5:0]  mem_addr;
    logic [31:0] mem [64];
    int          n_chk = 0, n_bad = 0;
`ifdef ARB_MISALIGN_CHK_EN
    logic        if_err, d_err;
`endif

    unified_mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
`ifdef ARB_MISALIGN_CHK_EN
        .if_err(if_err), .d_err(d_err),
`endif
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end else mem_rdata <= mem[mem_addr];
        end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE_0000 + i;
        mem_rdata = '0;
        rst_n = 0; if_req = 1; if_addr = 0;
        d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;
        #3;
        chk("rst_if_gnt", 32'(if_gnt), 0);
        chk("rst_mem_en", 32'(mem_en), 0);
        chk("rst_if_rvalid", 32'(if_rvalid), 0);
        chk("rst_d_rvalid", 32'(d_rvalid), 0);
        tick; tick;
        // fetch stream 0,4,8
        rst_n = 1; #1;
        chk("rel_if_gnt", 32'(if_gnt), 1);
        chk("fs_addr0", 32'(mem_addr), 0);
        for (int k = 1; k <= 3; k++) begin
            tick;
            chk("fs_rvalid", 32'(if_rvalid), 1);
            chk("fs_rdata", if_rdata, 32'hC0DE_0000 + k - 1);
            if (k < 3) begin
                if_addr = 8'(4 * k); #1;
                chk("fs_addr", 32'(mem_addr), k);
            end
        end
        if_req = 0; #1;
        chk("idle_mem_en", 32'(mem_en), 0);
        tick;
        // conflict: data wins, fetch next cycle
        if_req = 1; if_addr = 8'h10; d_req = 1; d_addr = 8'h04; #1;
        chk("cf_d_gnt", 32'(d_gnt), 1);
        chk("cf_if_gnt", 32'(if_gnt), 0);
        chk("cf_mem_addr", 32'(mem_addr), 1);
        chk("cf_rd_be", 32'(mem_be), 0);
        tick;
        d_req = 0; #1;
        chk("cf_d_rvalid", 32'(d_rvalid), 1);
        chk("cf_d_rdata", d_rdata, 32'hC0DE_0001);
        chk("cf_if_gnt2", 32'(if_gnt), 1);
        chk("cf_mem_addr2", 32'(mem_addr), 4);
        tick;
        chk("cf_if_rdata", if_rdata, 32'hC0DE_0004);
        chk("cf_d_rvalid0", 32'(d_rvalid), 0);
        // starvation guard
        if_addr = 0; d_addr = 8'h08; d_req = 1;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk("st_d_gnt", 32'(d_gnt), (c != 4) ? 1 : 0);
            chk("st_if_gnt", 32'(if_gnt), (c == 4) ? 1 : 0);
            if (c > 0) chk("st_if_rvalid", 32'(if_rvalid), (c == 5) ? 1 : 0);
            tick;
        end
        d_req = 0; if_req = 0;
        // store with partial byte enables
        d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 8'h0C; d_wdata = 32'hDEADBEEF; #1;
        chk("sw_mem_we", 32'(mem_we), 1);
        chk("sw_mem_addr", 32'(mem_addr), 3);
        chk("sw_mem_be", 32'(mem_be), 32'b0011);
        chk("sw_mem_wdata", mem_wdata, 32'hDEADBEEF);
        tick;
        d_we = 0; d_addr = 8'h0E; #1;
        chk("sw_ack", 32'(d_rvalid), 1);
        chk("sw_rdata0", d_rdata, 0);
        tick;
        chk("sw_readback", d_rdata, 32'hC0DE_BEEF);
        // store with no lanes still acks and changes nothing
        d_we = 1; d_be = 4'b0000; d_wdata = 32'hFFFF_FFFF; d_addr = 8'h0C; #1;
        chk("sw0_gnt", 32'(d_gnt), 1);
        chk("sw0_be", 32'(mem_be), 0);
        tick;
        d_we = 0; #1;
        chk("sw0_ack", 32'(d_rvalid), 1);
        tick;
        d_req = 0;
        chk("sw0_readback", d_rdata, 32'hC0DE_BEEF);
        // reset with a load response in flight
        d_req = 1; d_addr = 8'h08; #1;
        chk("rm_d_gnt", 32'(d_gnt), 1);
        tick;
        d_req = 0; rst_n = 0; #1;
        chk("rm_drop", 32'(d_rvalid), 0);
        tick;
        chk("rm_drop2", 32'(d_rvalid), 0);
        rst_n = 1; #1;
        chk("rm_after", 32'(d_rvalid), 0);
`ifdef ARB_MISALIGN_CHK_EN
        if_req = 1; if_addr = 8'h02; #1;
        chk("mis_if_gnt", 32'(if_gnt), 1);
        chk("mis_mem_en", 32'(mem_en), 0);
        tick;
        if_req = 0; #1;
        chk("mis_rvalid", 32'(if_rvalid), 1);
        chk("mis_err", 32'(if_err), 1);
        chk("mis_rdata", if_rdata, 0);
`endif
        tick;
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
